// File: rtl/toast_dmem_pkg.sv
// rtl/toast_dmem_pkg.sv - address map, STATUS bit layout and UART state type for the Toast data-memory bridge
package toast_dmem_pkg;

    localparam logic [31:0] DMEM_RAM_BASE  = 32'h0000_0000;
    localparam logic [31:0] DMEM_MMIO_BASE = 32'h8000_0000;
    localparam logic [31:0] MMIO_TXDATA    = 32'h8000_0000;
    localparam logic [31:0] MMIO_STATUS    = 32'h8000_0004;
    localparam logic [31:0] MMIO_CYCLE     = 32'h8000_0008;

    localparam int STATUS_FULL     = 0;
    localparam int STATUS_EMPTY    = 1;
    localparam int STATUS_BUSY     = 2;
    localparam int STATUS_OVERFLOW = 3;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_t;

endpackage

// File: rtl/toast_uart_tx.sv
// rtl/toast_uart_tx.sv - 8N1 UART serializer; pulls a byte through ready when it can start a frame
module toast_uart_tx
    import toast_dmem_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       busy,
    output logic       tx
);

    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    uart_state_t state, state_d;
    logic [BW-1:0] baud, baud_d;
    logic [2:0]    bit_idx, bit_d;
    logic [7:0]    shreg, shreg_d;
    logic          baud_end;

    assign baud_end = (baud == BW'(CLKS_PER_BIT - 1));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= UART_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_d;
            baud    <= baud_d;
            bit_idx <= bit_d;
            shreg   <= shreg_d;
        end
    end

    always_comb begin
        state_d = state;
        baud_d  = baud;
        bit_d   = bit_idx;
        shreg_d = shreg;
        ready   = 1'b0;
        case (state)
            UART_IDLE: begin
                if (valid) begin
                    ready   = 1'b1;
                    state_d = UART_START;
                    shreg_d = data;
                    baud_d  = '0;
                end
            end
            UART_START: begin
                if (baud_end) begin
                    state_d = UART_DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                end else begin
                    baud_d = baud + 1'b1;
                end
            end
            UART_DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shreg_d = {1'b0, shreg[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_d = UART_STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_idx + 3'd1;
                    end
                end else begin
                    baud_d = baud + 1'b1;
                end
            end
            UART_STOP: begin
                // Chain straight into the next start bit so queued bytes go out back to back
                if (baud_end) begin
                    baud_d = '0;
                    if (valid) begin
                        ready   = 1'b1;
                        state_d = UART_START;
                        shreg_d = data;
                    end else begin
                        state_d = UART_IDLE;
                    end
                end else begin
                    baud_d = baud + 1'b1;
                end
            end
            default: state_d = UART_IDLE;
        endcase
    end

    always_comb begin
        tx = 1'b1;
        case (state)
            UART_START: tx = 1'b0;
            UART_DATA:  tx = shreg[0];
            default:    tx = 1'b1;
        endcase
    end

    assign busy = (state != UART_IDLE);

endmodule

// File: rtl/toast_dmem_bridge.sv
// rtl/toast_dmem_bridge.sv - Toast core data port bridge: word RAM, UART TX FIFO and STATUS/CYCLE registers
module toast_dmem_bridge
    import toast_dmem_pkg::*;
#(
    parameter int RAM_DEPTH    = 1024,
    parameter int FIFO_DEPTH   = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wr_data,
    input  logic        mem_wr_en,
    input  logic        mem_rst,
    output logic [31:0] mem_rd_data,
    output logic        uart_tx
);

    localparam int AW = $clog2(RAM_DEPTH);
    localparam int FW = $clog2(FIFO_DEPTH);

    logic [31:0]   ram [RAM_DEPTH];
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [FW-1:0] wr_ptr, rd_ptr;
    logic [FW:0]   count;
    logic [31:0]   cycle_cnt, rd_next, status_word, word_addr;
    logic          ram_hit, txdata_hit, status_hit, cycle_hit;
    logic          fifo_full, fifo_empty, push_req, push, pop, overflow, tx_busy;

    assign word_addr  = mem_addr & 32'hFFFF_FFFC;
    assign ram_hit    = (mem_addr[31:28] == DMEM_RAM_BASE[31:28]);
    assign txdata_hit = (word_addr == MMIO_TXDATA);
    assign status_hit = (word_addr == MMIO_STATUS);
    assign cycle_hit  = (word_addr == MMIO_CYCLE);

    assign fifo_full  = (count == (FW+1)'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign push_req   = mem_wr_en & txdata_hit;
    assign push       = push_req & ~fifo_full;

    always_ff @(posedge Clk) begin
        if (mem_wr_en && ram_hit) begin
            ram[mem_addr[AW+1:2]] <= mem_wr_data;
        end
        if (push) begin
            fifo_mem[wr_ptr] <= mem_wr_data[7:0];
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            cycle_cnt   <= '0;
            mem_rd_data <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A dropped push outranks a clearing STATUS read in the same cycle
            if (push_req && fifo_full) begin
                overflow <= 1'b1;
            end else if (status_hit && !mem_wr_en) begin
                overflow <= 1'b0;
            end
            if (mem_wr_en && cycle_hit) begin
                cycle_cnt <= mem_wr_data;
            end else begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            mem_rd_data <= mem_rst ? 32'd0 : rd_next;
        end
    end

    always_comb begin
        status_word                  = '0;
        status_word[STATUS_FULL]     = fifo_full;
        status_word[STATUS_EMPTY]    = fifo_empty;
        status_word[STATUS_BUSY]     = tx_busy;
        status_word[STATUS_OVERFLOW] = overflow;
    end

    // CYCLE reads return the value the counter takes on the capturing edge
    always_comb begin
        rd_next = '0;
        if (ram_hit) begin
            rd_next = ram[mem_addr[AW+1:2]];
        end else if (status_hit) begin
            rd_next = status_word;
        end else if (cycle_hit) begin
            rd_next = cycle_cnt + 32'd1;
        end
    end

    toast_uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .Clk   (Clk),
        .Reset (Reset),
        .data  (fifo_mem[rd_ptr]),
        .valid (~fifo_empty),
        .ready (pop),
        .busy  (tx_busy),
        .tx    (uart_tx)
    );

endmodule

// File: tb/tb_toast_dmem_bridge.sv
// tb/tb_toast_dmem_bridge.sv - directed and randomized bench for toast_dmem_bridge against a frame-level model
module tb_toast_dmem_bridge;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;
    localparam logic [31:0] TXD = 32'h8000_0000;
    localparam logic [31:0] STS = 32'h8000_0004;
    localparam logic [31:0] CYC = 32'h8000_0008;
    localparam logic [31:0] NOP = 32'h4000_0000;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wr_data = '0;
    logic        mem_wr_en = 1'b0;
    logic        mem_rst = 1'b0;
    logic [31:0] mem_rd_data;
    logic        uart_tx;

    int n_tests = 0;
    int n_fail = 0;

    always #5 Clk = ~Clk;

    toast_dmem_bridge #(
        .RAM_DEPTH(1024),
        .FIFO_DEPTH(8),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_wr_en   (mem_wr_en),
        .mem_rst     (mem_rst),
        .mem_rd_data (mem_rd_data),
        .uart_tx     (uart_tx)
    );

    // Reference model: RAM words, byte queue, and the frame currently on the wire
    logic [31:0] m_ram [int];
    byte unsigned m_q[$];
    logic        m_ovf;
    logic [31:0] m_cycle;
    bit          m_active;
    int          m_pos;
    logic [7:0]  m_byte;
    logic [31:0] exp_rd;
    bit          exp_rd_known;
    logic        exp_tx;
    bit          chk_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic frame_bit(input int pos, input logic [7:0] b);
        int k;
        k = pos / CPB;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ovf = 1'b0;
        m_cycle = '0;
        m_active = 0;
        m_pos = 0;
        m_byte = '0;
        exp_rd = '0;
        exp_rd_known = 1;
        exp_tx = 1'b1;
    endtask

    task automatic model_step(input logic [31:0] a, input logic [31:0] d, input logic we, input logic mr);
        logic [31:0] val;
        logic [31:0] wa;
        logic [7:0]  pb;
        bit known, popped, full_pre;
        int idx;
        val = '0;
        known = 1;
        popped = 0;
        pb = '0;
        wa = a & 32'hFFFF_FFFC;
        idx = int'(a[11:2]);
        full_pre = (m_q.size() == 8);
        if (a[31:28] == 4'h0) begin
            if (m_ram.exists(idx)) val = m_ram[idx];
            else known = 0;
        end else if (wa == STS) begin
            val = {28'd0, m_ovf, m_active, (m_q.size() == 0), full_pre};
        end else if (wa == CYC) begin
            val = m_cycle + 32'd1;
        end
        if (mr) begin
            val = '0;
            known = 1;
        end
        exp_rd = val;
        exp_rd_known = known;
        if (we && a[31:28] == 4'h0) m_ram[idx] = d;
        m_cycle = (we && wa == CYC) ? d : m_cycle + 32'd1;
        if (m_q.size() > 0 && (!m_active || m_pos == FRAME - 1)) begin
            popped = 1;
            pb = m_q.pop_front();
        end
        if (we && wa == TXD) begin
            if (full_pre) m_ovf = 1'b1;
            else m_q.push_back(d[7:0]);
        end else if (wa == STS && !we) begin
            m_ovf = 1'b0;
        end
        if (popped) begin
            m_active = 1;
            m_pos = 0;
            m_byte = pb;
        end else if (m_active) begin
            m_pos++;
            if (m_pos == FRAME) m_active = 0;
        end
        exp_tx = m_active ? frame_bit(m_pos, m_byte) : 1'b1;
    endtask

    task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic we, input logic mr);
        @(negedge Clk);
        mem_addr = a;
        mem_wr_data = d;
        mem_wr_en = we;
        mem_rst = mr;
        model_step(a, d, we, mr);
        @(posedge Clk);
        #2;
    endtask

    task automatic do_reset();
        chk_en = 0;
        Reset = 1'b1;
        mem_wr_en = 1'b0;
        mem_rst = 1'b0;
        repeat (2) @(posedge Clk);
        #2;
        Reset = 1'b0;
        model_reset();
        chk_en = 1;
    endtask

    always @(posedge Clk) begin
        #1;
        if (chk_en) begin
            if (exp_rd_known) check("rd_data", mem_rd_data, exp_rd);
            check("uart_tx", {31'd0, uart_tx}, {31'd0, exp_tx});
        end
    end

    // Line receiver: frames start on a low level and are sampled mid-bit
    byte unsigned rx_q[$];
    int          rx_pos = -1;
    logic [7:0]  rx_b = '0;
    always @(posedge Clk or posedge Reset) begin
        #1;
        if (Reset) begin
            rx_pos = -1;
        end else if (rx_pos < 0) begin
            if (uart_tx == 1'b0) rx_pos = 0;
        end else begin
            rx_pos++;
            if (rx_pos % CPB == CPB / 2 && rx_pos / CPB >= 1 && rx_pos / CPB <= 8)
                rx_b[rx_pos/CPB-1] = uart_tx;
            if (rx_pos == FRAME - 1) begin
                rx_q.push_back(rx_b);
                rx_pos = -1;
            end
        end
    end

    initial begin
        logic [9:0]  tx_seen;
        logic [31:0] a;
        logic        we;
        int          r;

        repeat (3) @(posedge Clk);
        #1;
        check("reset_rd", mem_rd_data, 32'd0);
        check("reset_tx", {31'd0, uart_tx}, 32'd1);
        do_reset();

        cyc(32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0);
        cyc(32'h0000_0010, 32'd0, 1'b0, 1'b0);
        check("ram_read", mem_rd_data, 32'hDEAD_BEEF);
        cyc(32'h0000_1010, 32'd0, 1'b0, 1'b0);
        check("ram_alias", mem_rd_data, 32'hDEAD_BEEF);
        cyc(32'h0000_0010, 32'h1111_1111, 1'b1, 1'b0);
        check("ram_read_first", mem_rd_data, 32'hDEAD_BEEF);
        cyc(32'h0000_0010, 32'd0, 1'b0, 1'b0);
        check("ram_new", mem_rd_data, 32'h1111_1111);

        cyc(32'h0000_0020, 32'h1234_5678, 1'b1, 1'b0);
        cyc(32'h0000_0020, 32'd0, 1'b0, 1'b1);
        check("mem_rst", mem_rd_data, 32'd0);
        cyc(NOP, 32'd0, 1'b0, 1'b0);
        check("unmapped", mem_rd_data, 32'd0);
        cyc(32'h0000_0020, 32'd0, 1'b0, 1'b0);
        check("ram_after_rst", mem_rd_data, 32'h1234_5678);

        cyc(CYC, 32'hFFFF_FFFE, 1'b1, 1'b0);
        cyc(CYC, 32'd0, 1'b0, 1'b0);
        check("cycle_1", mem_rd_data, 32'hFFFF_FFFF);
        cyc(CYC, 32'd0, 1'b0, 1'b0);
        check("cycle_wrap", mem_rd_data, 32'd0);

        cyc(TXD, 32'h55, 1'b1, 1'b0);
        check("tx_idle_at_push", {31'd0, uart_tx}, 32'd1);
        tx_seen = '0;
        for (int k = 1; k <= FRAME; k++) begin
            cyc(NOP, 32'd0, 1'b0, 1'b0);
            if (k == 1) check("start_latency", {31'd0, uart_tx}, 32'd0);
            if (k % CPB == 2) tx_seen[k/CPB] = uart_tx;
        end
        check("frame_55", {22'd0, tx_seen}, 32'h2AA);
        cyc(NOP, 32'd0, 1'b0, 1'b0);
        cyc(STS, 32'd0, 1'b0, 1'b0);
        check("status_idle", mem_rd_data, 32'h2);

        rx_q.delete();
        for (int i = 0; i < 10; i++) cyc(TXD, 32'hA0 + i, 1'b1, 1'b0);
        cyc(STS, 32'd0, 1'b0, 1'b0);
        check("status_ovf", mem_rd_data, 32'hD);
        cyc(STS, 32'd0, 1'b0, 1'b0);
        check("status_ovf_clr", mem_rd_data, 32'h5);
        repeat (9 * FRAME + 20) cyc(NOP, 32'd0, 1'b0, 1'b0);
        check("frame_count", rx_q.size(), 32'd9);
        for (int i = 0; i < rx_q.size() && i < 9; i++)
            check("frame_byte", {24'd0, rx_q[i]}, 32'hA0 + i);
        cyc(STS, 32'd0, 1'b0, 1'b0);
        check("status_drained", mem_rd_data, 32'h2);

        rx_q.delete();
        cyc(TXD, 32'hC3, 1'b1, 1'b0);
        cyc(TXD, 32'h5A, 1'b1, 1'b0);
        repeat (17) cyc(NOP, 32'd0, 1'b0, 1'b0);
        check("tx_bit3_low", {31'd0, uart_tx}, 32'd0);
        chk_en = 0;
        #1;
        Reset = 1'b1;
        #1;
        check("reset_async_tx", {31'd0, uart_tx}, 32'd1);
        do_reset();
        cyc(STS, 32'd0, 1'b0, 1'b0);
        check("status_after_reset", mem_rd_data, 32'h2);
        repeat (100) cyc(NOP, 32'd0, 1'b0, 1'b0);
        check("no_residual_frame", rx_q.size(), 32'd0);

        for (int i = 0; i < 16; i++) cyc(32'(i * 4), $urandom, 1'b1, 1'b0);
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3: a = (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 7)) << 12)
                                | 32'($urandom_range(0, 3));
                4, 9: a = TXD;
                5: a = STS;
                6: a = CYC | 32'($urandom_range(0, 3));
                7: a = NOP | 32'($urandom_range(0, 255));
                default: a = 32'h8000_000C;
            endcase
            we = ($urandom_range(0, 2) == 0);
            cyc(a, $urandom, we, ($urandom_range(0, 9) == 0));
        end
        repeat (8 * FRAME + 10) cyc(NOP, 32'd0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
